bounce_emulator: RTL and testbench
==================================

// Module: bounce_emulator
// PURPOSE
//  Generates a mechanically "bouncy" copy of a clean logic level. Used to drive
//  the debounce FSM on-board and in simulation without a physical switch.
//  Each level change on clean_in becomes a burst of pseudo-random glitches,
//  then a settled level, on bounce_out.
//  Sits between the switch/stimulus source and debounce.in.
// PARAMETERS
//  TICK_DIV          100_000  clk cycles per bounce tick (1 ms at 100 MHz); >=2
//  NUM_BOUNCES       5        glitch pairs per transition; 0 = clean edge
//  MAX_GLITCH_TICKS  4        max ticks per glitch half; power of 2, 1..16
//  SETTLE_TICKS      10       ticks bounce_out holds target before done; >=1
//  LFSR_SEED         16'hACE1 LFSR reset value; must be nonzero
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  clean_in   in   1   desired (ideal) switch level
//  bypass     in   1   1 = bounce_out <= clean_in each clk, FSM held IDLE
//  bounce_out out  1   emulated bouncy switch output (registered)
//  busy       out  1   high from first glitch through end of SETTLE
//  done       out  1   one-clk pulse when a transition has fully settled
// BEHAVIOUR
//  Reset (sync): bounce_out=0, busy=0, done=0, state=IDLE, div=0, lfsr=LFSR_SEED.
//  Reset asserted mid-burst: all regs take reset values at that edge; burst aborted.
//  Tick: div counts 0..TICK_DIV-1 while state!=IDLE.
//    div is cleared on IDLE exit. tick=1 when div==TICK_DIV-1.
//  LFSR: 16-bit Galois, mask 16'hB400. Advances once per tick.
//  glen = (lfsr & (MAX_GLITCH_TICKS-1)) + 1, sampled on entry to each glitch half.
//  FSM states and transitions:
//   IDLE: busy=0. If !bypass && clean_in!=bounce_out:
//     target<=clean_in, cnt<=NUM_BOUNCES, busy<=1.
//     NUM_BOUNCES==0 -> SETTLE, bounce_out<=target.
//     Otherwise -> GL_ON, bounce_out<=target.
//     bounce_out moves 1 clk after the mismatch is seen.
//   GL_ON: bounce_out=target for glen ticks -> GL_OFF, bounce_out<=~target.
//   GL_OFF: bounce_out=~target for glen ticks; cnt<=cnt-1.
//     cnt becomes 0 -> SETTLE, bounce_out<=target.
//     Otherwise -> GL_ON, bounce_out<=target.
//   SETTLE: bounce_out=target for SETTLE_TICKS ticks.
//     Then done<=1 for 1 clk, busy<=0 -> IDLE.
//  clean_in changes while busy: ignored. IDLE re-compares on the next clk.
//    A toggle back to the original level during a burst therefore starts a new
//    burst right after done.
//  bypass=1: bounce_out<=clean_in every clk (1-clk latency). FSM forced IDLE.
//    busy=0, done=0. Deasserting bypass mid-burst is not a case: bypass wins.
//  Widths: cnt >= clog2(NUM_BOUNCES+1) bits; tick counters >= 5 bits; div $clog2(TICK_DIV).
//  done and busy are registered; busy and done are never high in the same cycle.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, GL_ON, GL_OFF, SETTLE) and LFSR mask
//  constant 16'hB400.
//  Sub-module lfsr16 (clk, reset, en, seed, q): sync-reset Galois LFSR, en=tick.
//  Divider, counters and FSM stay in bounce_emulator.
// TESTING  (TICK_DIV=4, NUM_BOUNCES=3, MAX_GLITCH_TICKS=2, SETTLE_TICKS=2)
//  1 Reset, clean_in=0 -> bounce_out=0, busy=0, done=0. No activity for 100 clk.
//  2 clean_in 0->1 -> bounce_out rises 1 clk later.
//    Exactly 3 falling glitches follow, each half 4 or 8 clk.
//    Then bounce_out stays 1 for 8 clk, done pulses once, busy falls.
//  3 NUM_BOUNCES=0 build, clean_in 1->0 -> bounce_out falls 1 clk later, no glitches.
//    done fires 8 clk after the fall.
//  4 clean_in toggles 1->0 mid-burst -> first burst completes to 1 with done.
//    Next clk a new burst toward 0 begins.
//  5 Reset pulsed mid-GL_OFF -> bounce_out=0, busy=0 next clk.
//    Burst glitch lengths repeat identically to scenario 2 (same LFSR_SEED).
//  6 bypass=1, clean_in toggled every clk -> bounce_out=clean_in delayed 1 clk.
//    busy and done stay 0.

Source files
------------

// File: rtl/bounce_emulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_emulator_pkg
//  Description : Shared FSM encoding and LFSR constants for bounce_emulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package bounce_emulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GL_ON  = 2'd1,
        ST_GL_OFF = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam logic [15:0] c_lfsr_mask = 16'hB400;

    // One right-shifting Galois step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ c_lfsr_mask) : (q >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit Galois LFSR, loads seed on reset, steps when en=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import bounce_emulator_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= seed;
        end else if (en) begin
            r_q <= lfsr_step(r_q);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/bounce_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_emulator
//  Description : Turns each level change of clean_in into a pseudo-random
//                glitch burst followed by a settled level on bounce_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module bounce_emulator
    import bounce_emulator_pkg::*;
#(
    parameter int          TICK_DIV         = 100_000,
    parameter int          NUM_BOUNCES      = 5,
    parameter int          MAX_GLITCH_TICKS = 4,
    parameter int          SETTLE_TICKS     = 10,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic clean_in,
    input  logic bypass,
    output logic bounce_out,
    output logic busy,
    output logic done
);

    localparam int c_div_w = $clog2(TICK_DIV);
    localparam int c_cnt_w = (NUM_BOUNCES > 0) ? $clog2(NUM_BOUNCES + 1) : 1;
    localparam int c_tk_w  = ($clog2(SETTLE_TICKS + 1) > 5) ? $clog2(SETTLE_TICKS + 1) : 5;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(TICK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_tk_w-1:0]  c_tk_one   = c_tk_w'(1);
    localparam logic [c_tk_w-1:0]  c_settle   = c_tk_w'(SETTLE_TICKS);
    localparam logic [15:0]        c_glen_msk = 16'(MAX_GLITCH_TICKS - 1);

    state_t             r_state, w_state_nxt;
    logic [c_div_w-1:0] r_div;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [c_tk_w-1:0]  r_ticks, w_ticks_nxt;
    logic               r_target, w_target_nxt;
    logic               r_bounce, w_bounce_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               w_tick;
    logic [15:0]        w_lfsr;
    logic [c_tk_w-1:0]  w_glen;

    assign w_tick = (r_state != ST_IDLE) && (r_div == c_div_last);
    assign w_glen = c_tk_w'(w_lfsr & c_glen_msk) + c_tk_one;

    // Divider only runs during a burst, so every burst starts on a fresh tick phase.
    always_ff @(posedge clk) begin
        if (reset || bypass || r_state == ST_IDLE || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (w_tick),
        .seed  (LFSR_SEED),
        .q     (w_lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ticks  <= '0;
            r_target <= 1'b0;
            r_bounce <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ticks  <= w_ticks_nxt;
            r_target <= w_target_nxt;
            r_bounce <= w_bounce_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ticks_nxt  = r_ticks;
        w_target_nxt = r_target;
        w_bounce_nxt = r_bounce;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        if (bypass) begin
            w_state_nxt  = ST_IDLE;
            w_bounce_nxt = clean_in;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_busy_nxt = 1'b0;
                    if (clean_in != r_bounce) begin
                        w_target_nxt = clean_in;
                        w_bounce_nxt = clean_in;
                        w_cnt_nxt    = c_cnt_w'(NUM_BOUNCES);
                        w_busy_nxt   = 1'b1;
                        if (NUM_BOUNCES == 0) begin
                            w_state_nxt = ST_SETTLE;
                            w_ticks_nxt = c_settle;
                        end else begin
                            w_state_nxt = ST_GL_ON;
                            w_ticks_nxt = w_glen;
                        end
                    end
                end
                ST_GL_ON: begin
                    if (w_tick) begin
                        if (r_ticks == c_tk_one) begin
                            w_state_nxt  = ST_GL_OFF;
                            w_bounce_nxt = ~r_target;
                            w_ticks_nxt  = w_glen;
                        end else begin
                            w_ticks_nxt = r_ticks - 1'b1;
                        end
                    end
                end
                ST_GL_OFF: begin
                    if (w_tick) begin
                        if (r_ticks == c_tk_one) begin
                            w_cnt_nxt    = r_cnt - 1'b1;
                            w_bounce_nxt = r_target;
                            if (r_cnt == c_cnt_one) begin
                                w_state_nxt = ST_SETTLE;
                                w_ticks_nxt = c_settle;
                            end else begin
                                w_state_nxt = ST_GL_ON;
                                w_ticks_nxt = w_glen;
                            end
                        end else begin
                            w_ticks_nxt = r_ticks - 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (w_tick) begin
                        if (r_ticks == c_tk_one) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_ticks_nxt = r_ticks - 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign bounce_out = r_bounce;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bounce_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bounce_emulator
//  Description : Scoreboard bench for bounce_emulator (3-bounce and 0-bounce builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bounce_emulator;

    typedef struct packed {
        logic        is_done;
        logic        lvl;
        logic        busy;
        logic [15:0] gap;
    } ev_t;

    logic clk;
    logic reset;
    logic clean_in, bypass, bounce_out, busy, done;
    logic clean0, bypass0, bounce0, busy0, done0;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t_ref [2];
    logic prev_bo [2];
    logic mon_en = 1'b0;
    ev_t  q0 [$];
    ev_t  q1 [$];

    bounce_emulator #(
        .TICK_DIV(4), .NUM_BOUNCES(3), .MAX_GLITCH_TICKS(2), .SETTLE_TICKS(2), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .clean_in(clean_in), .bypass(bypass),
        .bounce_out(bounce_out), .busy(busy), .done(done)
    );

    bounce_emulator #(
        .TICK_DIV(4), .NUM_BOUNCES(0), .MAX_GLITCH_TICKS(2), .SETTLE_TICKS(2), .LFSR_SEED(16'hACE1)
    ) dut0 (
        .clk(clk), .reset(reset), .clean_in(clean0), .bypass(bypass0),
        .bounce_out(bounce0), .busy(busy0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void push(input int d, input logic dn, input logic lv, input logic bz, input int gap);
        ev_t e;
        e = {dn, lv, bz, 16'(gap)};
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    // Rise/fall to target, six glitch-half lengths (clk), settle, done.
    function automatic void push_burst(input int d, input logic tgt,
                                       input int h0, input int h1, input int h2,
                                       input int h3, input int h4, input int h5);
        int h [6];
        h = '{h0, h1, h2, h3, h4, h5};
        push(d, 1'b0, tgt, 1'b1, 1);
        for (int i = 0; i < 6; i++) push(d, 1'b0, (i % 2 == 0) ? ~tgt : tgt, 1'b1, h[i]);
        push(d, 1'b1, tgt, 1'b0, 8);
    endfunction

    function automatic void observe(input int d, input ev_t got);
        ev_t e;
        checks++;
        if (qsize(d) == 0) begin
            errors++;
            $display("FAIL unexpected_event dut%0d: got done=%0b lvl=%0b busy=%0b gap=%0d, required none",
                     d, got.is_done, got.lvl, got.busy, got.gap);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (got !== e) begin
            errors++;
            $display("FAIL event dut%0d: got done=%0b lvl=%0b busy=%0b gap=%0d, required done=%0b lvl=%0b busy=%0b gap=%0d",
                     d, got.is_done, got.lvl, got.busy, got.gap, e.is_done, e.lvl, e.busy, e.gap);
        end
    endfunction

    // Every bounce_out change and every done pulse is an event; gap counts clk since the previous one.
    always @(negedge clk) begin : monitor
        logic bo [2];
        logic bz [2];
        logic dn [2];
        cyc = cyc + 1;
        bo[0] = bounce_out; bz[0] = busy;  dn[0] = done;
        bo[1] = bounce0;    bz[1] = busy0; dn[1] = done0;
        for (int d = 0; d < 2; d++) begin
            if (mon_en) begin
                if (bo[d] !== prev_bo[d]) begin
                    observe(d, {1'b0, bo[d], bz[d], 16'(cyc - t_ref[d])});
                    t_ref[d] = cyc;
                end
                if (dn[d] === 1'b1) begin
                    observe(d, {1'b1, bo[d], bz[d], 16'(cyc - t_ref[d])});
                    t_ref[d] = cyc;
                    checks++;
                    if (bz[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL busy_with_done dut%0d: got busy=%b, required 0", d, bz[d]);
                    end
                end
            end
            prev_bo[d] = bo[d];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic wait_until(input int d, input int left, input int budget);
        int n;
        n = 0;
        while (qsize(d) > left && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (qsize(d) > left) begin
            errors++;
            $display("FAIL event_timeout dut%0d: got %0d pending, required %0d", d, qsize(d), left);
            if (d == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    // Drives land mid-cycle; the next negedge is the reference point for gaps.
    task automatic mark(input int d);
        t_ref[d] = cyc + 1;
    endtask

    initial begin
        reset = 1'b1; clean_in = 1'b0; bypass = 1'b0; clean0 = 1'b0; bypass0 = 1'b0;
        t_ref[0] = 0; t_ref[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bounce", bounce_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_bounce0", bounce0, 1'b0);
        check("reset_busy0", busy0, 1'b0);
        check("reset_done0", done0, 1'b0);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (100) step();
        check("idle_bounce", bounce_out, 1'b0);
        check("idle_busy", busy, 1'b0);

        // Seed 0xACE1 gives halves 8,4,4,4,4,8; the toggle back queues a second burst (8,4,4,4,8,4).
        clean_in = 1'b1; mark(0);
        push_burst(0, 1'b1, 8, 4, 4, 4, 4, 8);
        wait_until(0, 5, 200);
        clean_in = 1'b0;
        check("busy_mid_burst", busy, 1'b1);
        push_burst(0, 1'b0, 8, 4, 4, 4, 8, 4);
        wait_until(0, 0, 400);
        repeat (20) step();

        // Reset mid GL_OFF, then the same burst replays from the seed.
        reset = 1'b1; step(); reset = 1'b0;
        step();
        clean_in = 1'b1; mark(0);
        push(0, 1'b0, 1'b1, 1'b1, 1);
        push(0, 1'b0, 1'b0, 1'b1, 8);
        wait_until(0, 0, 100);
        check("busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        step();
        check("midreset_bounce", bounce_out, 1'b0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_done", done, 1'b0);
        reset = 1'b0; mark(0);
        push_burst(0, 1'b1, 8, 4, 4, 4, 4, 8);
        wait_until(0, 0, 400);
        repeat (20) step();

        // Bypass: one-clk copy of clean_in, no busy, no done.
        bypass = 1'b1; mark(0);
        for (int i = 0; i < 12; i++) begin
            clean_in = ~clean_in;
            push(0, 1'b0, clean_in, 1'b0, 1);
            step();
        end
        wait_until(0, 0, 20);
        bypass = 1'b0;
        repeat (20) step();
        check("post_bypass_bounce", bounce_out, clean_in);

        // Zero-bounce build: clean edges, done 8 clk later.
        clean0 = 1'b1; mark(1);
        push(1, 1'b0, 1'b1, 1'b1, 1);
        push(1, 1'b1, 1'b1, 1'b0, 8);
        wait_until(1, 0, 100);
        clean0 = 1'b0; mark(1);
        push(1, 1'b0, 1'b0, 1'b1, 1);
        push(1, 1'b1, 1'b0, 1'b0, 8);
        wait_until(1, 0, 100);
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
